sccb_config_sequencer: RTL and testbench
========================================

Name: sccb_config_sequencer

Overview:
Walks the camera register-init table and issues one SCCB register write per table entry to the SCCB byte-write engine, using a req/ack/nack handshake. It replaces the single-button kick of the SCCB interface with a sequenced bring-up. The sequencer inserts a settle delay after a camera soft-reset write, retries NACKed writes, and reports busy/done/error to the top level and LEDs.

Parameters:
ROM_DEPTH, 128, number of table entries; index width is clog2(ROM_DEPTH)
RESET_DELAY_CYCLES, 100_000, wait after soft-reset write (1 ms at 100 MHz clk)
GAP_CYCLES, 1_000, idle gap between consecutive writes
MAX_RETRY, 3, re-issues of a NACKed write before error
ACK_TIMEOUT, 50_000, cycles in WAIT_ACK before counting as NACK

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse (debounced button) begins sequence; ignored unless IDLE, DONE or ERROR
wr_req  out  1  write request to SCCB engine, level
wr_addr  out  8  camera register address
wr_data  out  8  register value
wr_ack  in  1  one-cycle pulse: write completed and acknowledged
wr_nack  in  1  one-cycle pulse: write completed, slave NACK
busy  out  1  high from start accepted until DONE/ERROR
done  out  1  level, high in DONE
error  out  1  level, high in ERROR
reg_idx  out  clog2(ROM_DEPTH)  index of current or last entry

Behaviour:
- Reset (reset=0, async): state IDLE; wr_req=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, reg_idx=0, all counters 0.
- ROM entry is 16 bits {addr,data}. 16'hFFFF marks end of table. Reaching index ROM_DEPTH-1 without an end marker also counts as end, after that entry is written.
- ROM read is synchronous, 1-cycle latency.
- IDLE: on start -> FETCH, idx=0, busy=1, retry=0.
- FETCH: 1 cycle to present idx; next cycle the entry is latched.
  - Entry == FFFF -> DONE.
  - Otherwise latch wr_addr/wr_data -> REQ.
- REQ: assert wr_req -> WAIT_ACK.
- WAIT_ACK: wr_req held high until wr_ack or wr_nack is sampled; wr_req deasserts the cycle after the response.
  - wr_ack: if the write was addr 0x12 with data[7]=1 -> DELAY with RESET_DELAY_CYCLES; else -> DELAY with GAP_CYCLES. retry=0.
  - wr_nack, or timeout reached: if retry<MAX_RETRY then retry++ and -> DELAY(GAP_CYCLES), then REQ again with the same idx. Otherwise -> ERROR.
  - wr_ack and wr_nack in the same cycle: treat as nack.
- DELAY: down-counter to 0.
  - On expiry, after a successful write: idx++, -> FETCH. If idx was ROM_DEPTH-1 -> DONE.
  - On expiry, on the retry path: -> REQ.
- DONE: done=1, busy=0. start -> restart from idx 0 (done cleared in same cycle start accepted).
- ERROR: error=1, busy=0, reg_idx frozen at the failing entry. start -> restart from idx 0, error cleared.
- start while busy: ignored, no effect on counters.
- Reset mid-write: wr_req drops immediately (async). The SCCB engine must tolerate an abandoned request.
- Counter widths: sized by clog2 of the largest delay/timeout parameter. No wrap allowed; counters saturate at 0.
- Latency: start to first wr_req = 3 cycles (IDLE->FETCH->latch->REQ).

Decomposition:
- Package sccb_cfg_pkg:
  - state enum (IDLE, FETCH, REQ, WAIT_ACK, DELAY, DONE, ERROR)
  - END_MARKER=16'hFFFF, SOFT_RESET_ADDR=8'h12
  - rom entry typedef {addr,data}
- Sub-module ov7670_reg_rom: synchronous ROM, case-statement init table, ports clk, addr, data[15:0]. Benches substitute a short test table.

Test Plan:
- Table {12,80},{11,01},FFFF; ack every write 10 cycles after wr_req. Required:
  - writes 12/80 then 11/01;
  - gap between the ack of 12/80 and the next wr_req = RESET_DELAY_CYCLES+2 (FETCH + latch cycles);
  - done=1, busy=0, reg_idx=2.
- Entry 1 NACKed twice then acked (MAX_RETRY=3). Required: wr_req asserted 3 times with identical addr/data, then proceeds; error=0.
- Entry 1 NACKed 4 times. Required: ERROR after 4th nack, error=1, reg_idx=1, wr_req=0; subsequent start restarts at idx 0 and clears error.
- No response (ACK_TIMEOUT=20). Required: timeout counted as nack; after MAX_RETRY+1 timeouts -> ERROR.
- start pulsed during WAIT_ACK. Required: no effect. Reset driven low mid-WAIT_ACK: wr_req=0 and all outputs at reset values the same cycle; the first start after reset release writes entry 0.
- Same-cycle wr_ack and wr_nack. Required: treated as nack, retry incremented, idx unchanged.

Source files
------------

// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
//   state_t     : sequencer FSM states
//   rom_entry_t : one init-table entry {register address, register value}
//   END_MARKER  : table entry that terminates the walk
//   SOFT_RESET_ADDR : camera COM7 register; writing bit 7 resets the sensor
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ,
        WAIT_ACK,
        DELAY,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } rom_entry_t;

    localparam logic [15:0] END_MARKER      = 16'hFFFF;
    localparam logic [7:0]  SOFT_RESET_ADDR = 8'h12;

    // True when the write resets the sensor and therefore needs the long settle time.
    function automatic logic is_soft_reset(input rom_entry_t e);
        return (e.addr == SOFT_RESET_ADDR) && e.data[7];
    endfunction

    // Largest of three values, used to size the shared delay/timeout counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Camera register-init table as a synchronous ROM (1-cycle read latency).
//   clk  : clock
//   addr : table index
//   data : {register address, register value}; 16'hFFFF ends the table
// TEST_TABLE selects a three-entry table used for bring-up of the sequencer.
module ov7670_reg_rom
    import sccb_cfg_pkg::*;
#(
    parameter int  ROM_DEPTH  = 128,
    parameter bit  TEST_TABLE = 1'b0,
    localparam int IW         = $clog2(ROM_DEPTH)
) (
    input  logic          clk,
    input  logic [IW-1:0] addr,
    output logic [15:0]   data
);

    logic [7:0] w_addr8;
    assign w_addr8 = 8'(addr);

    // Registered table lookup.
    always_ff @(posedge clk) begin
        if (TEST_TABLE) begin
            case (w_addr8)
                8'd0:    data <= 16'h1280;
                8'd1:    data <= 16'h1101;
                default: data <= END_MARKER;
            endcase
        end else begin
            case (w_addr8)
                8'd0:    data <= 16'h1280;   // COM7: sensor soft reset
                8'd1:    data <= 16'h1101;   // CLKRC: prescale /2
                8'd2:    data <= 16'h1204;   // COM7: RGB output
                8'd3:    data <= 16'h0C00;   // COM3
                8'd4:    data <= 16'h3E00;   // COM14
                8'd5:    data <= 16'h40D0;   // COM15: RGB565, full range
                8'd6:    data <= 16'h3A04;   // TSLB
                8'd7:    data <= 16'h1418;   // COM9: AGC ceiling
                8'd8:    data <= 16'h4FB3;   // MTX1
                8'd9:    data <= 16'h50B3;   // MTX2
                8'd10:   data <= 16'h5100;   // MTX3
                8'd11:   data <= 16'h523D;   // MTX4
                8'd12:   data <= 16'h53A7;   // MTX5
                8'd13:   data <= 16'h54E4;   // MTX6
                8'd14:   data <= 16'h589E;   // MTXS
                8'd15:   data <= 16'h3DC0;   // COM13: gamma, UV sat
                8'd16:   data <= 16'h1714;   // HSTART
                8'd17:   data <= 16'h1802;   // HSTOP
                8'd18:   data <= 16'h3280;   // HREF
                8'd19:   data <= 16'h1903;   // VSTART
                8'd20:   data <= 16'h1A7B;   // VSTOP
                8'd21:   data <= 16'h030A;   // VREF
                default: data <= END_MARKER;
            endcase
        end
    end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the camera init table and issues one SCCB register write per entry.
//   clk, reset(async, active-low)
//   start          : pulse, accepted in IDLE/DONE/ERROR, restarts at entry 0
//   wr_req/addr/data : level request to the SCCB byte-write engine
//   wr_ack/wr_nack : one-cycle completion pulses from the engine
//   busy/done/error : sequence status
//   reg_idx        : index of the current (or failing / last) entry
// A sensor soft-reset write is followed by a long settle delay; NACKed or
// timed-out writes are re-issued up to MAX_RETRY times before ERROR.
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int  ROM_DEPTH          = 128,
    parameter int  RESET_DELAY_CYCLES = 100_000,
    parameter int  GAP_CYCLES         = 1_000,
    parameter int  MAX_RETRY          = 3,
    parameter int  ACK_TIMEOUT        = 50_000,
    parameter bit  USE_TEST_TABLE     = 1'b0,
    localparam int IW                 = $clog2(ROM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          wr_req,
    output logic [7:0]    wr_addr,
    output logic [7:0]    wr_data,
    input  logic          wr_ack,
    input  logic          wr_nack,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] reg_idx
);

    localparam int CW = $clog2(max3(RESET_DELAY_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    // Counter loads are N-1 so the state lasts exactly N cycles.
    localparam logic [CW-1:0] C_RST   = CW'(RESET_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] C_TMO   = CW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] C_RETRY = RW'(MAX_RETRY);
    localparam logic [IW-1:0] C_LAST  = IW'(ROM_DEPTH - 1);

    state_t        r_state;
    logic          r_fetch_ph;   // 0: ROM address presented, 1: ROM data valid
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;        // shared settle / gap / ack-timeout counter
    logic [RW-1:0] r_retry;
    logic          r_succ;       // DELAY follows an acknowledged write
    logic          r_wr_req;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic [15:0]   w_rom_data;
    rom_entry_t    w_entry;
    rom_entry_t    w_last_wr;
    logic          w_fail;

    assign w_entry   = w_rom_data;
    assign w_last_wr = {r_wr_addr, r_wr_data};
    // NACK wins over a simultaneous ACK; an expired timeout counts as NACK.
    assign w_fail    = wr_nack || (!wr_ack && (r_cnt == {CW{1'b0}}));

    ov7670_reg_rom #(
        .ROM_DEPTH  (ROM_DEPTH),
        .TEST_TABLE (USE_TEST_TABLE)
    ) u_rom (
        .clk  (clk),
        .addr (r_idx),
        .data (w_rom_data)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_ph <= 1'b0;
            r_idx      <= {IW{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_retry    <= {RW{1'b0}};
            r_succ     <= 1'b0;
            r_wr_req   <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state    <= FETCH;
                        r_fetch_ph <= 1'b0;
                        r_idx      <= {IW{1'b0}};
                        r_retry    <= {RW{1'b0}};
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (!r_fetch_ph) begin
                        r_fetch_ph <= 1'b1;
                    end else begin
                        r_fetch_ph <= 1'b0;
                        if (w_rom_data == END_MARKER) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_wr_addr <= w_entry.addr;
                            r_wr_data <= w_entry.data;
                            r_wr_req  <= 1'b1;
                            r_state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    r_cnt   <= C_TMO;
                    r_state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (w_fail) begin
                        r_wr_req <= 1'b0;
                        if (r_retry < C_RETRY) begin
                            r_retry <= r_retry + 1'b1;
                            r_succ  <= 1'b0;
                            r_cnt   <= C_GAP;
                            r_state <= DELAY;
                        end else begin
                            r_state <= ERROR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end
                    end else if (wr_ack) begin
                        r_wr_req <= 1'b0;
                        r_retry  <= {RW{1'b0}};
                        r_succ   <= 1'b1;
                        r_cnt    <= is_soft_reset(w_last_wr) ? C_RST : C_GAP;
                        r_state  <= DELAY;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DELAY: begin
                    if (r_cnt != {CW{1'b0}}) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_succ) begin
                        r_wr_req <= 1'b1;
                        r_state  <= REQ;
                    end else if (r_idx == C_LAST) begin
                        // Table exhausted without an end marker.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx      <= r_idx + 1'b1;
                        r_fetch_ph <= 1'b0;
                        r_state    <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr_req  = r_wr_req;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;
    assign reg_idx = r_idx;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
module tb_sccb_config_sequencer;

    localparam int RST_D = 40;
    localparam int GAP   = 5;
    localparam int TMO   = 20;
    localparam int MAXR  = 3;

    localparam int C_ACK  = 0;
    localparam int C_NACK = 1;
    localparam int C_BOTH = 2;
    localparam int C_NONE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       wr_ack = 1'b0;
    logic       wr_nack = 1'b0;
    logic       wr_req, busy, done, error;
    logic [7:0] wr_addr, wr_data;
    logic [6:0] reg_idx;

    logic       start2 = 1'b0;
    logic       wr_ack2 = 1'b0;
    logic       wr_nack2 = 1'b0;
    logic       wr_req2, busy2, done2, error2;
    logic [7:0] wr_addr2, wr_data2;
    logic [0:0] reg_idx2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fixed_dly = 0;
    int codes[$];
    int resp_q[$];
    int rise_q[$];
    int ack_q[$];
    logic [15:0] exp_q[$];
    int cnt2 = 0;
    logic [15:0] last2 = 16'h0000;

    sccb_config_sequencer #(
        .ROM_DEPTH(128), .RESET_DELAY_CYCLES(RST_D), .GAP_CYCLES(GAP),
        .MAX_RETRY(MAXR), .ACK_TIMEOUT(TMO), .USE_TEST_TABLE(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_nack(wr_nack),
        .busy(busy), .done(done), .error(error), .reg_idx(reg_idx)
    );

    // Two-entry table with no end marker: ends after writing the last index.
    sccb_config_sequencer #(
        .ROM_DEPTH(2), .RESET_DELAY_CYCLES(RST_D), .GAP_CYCLES(GAP),
        .MAX_RETRY(MAXR), .ACK_TIMEOUT(TMO), .USE_TEST_TABLE(1'b1)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .wr_req(wr_req2),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ack(wr_ack2), .wr_nack(wr_nack2),
        .busy(busy2), .done(done2), .error(error2), .reg_idx(reg_idx2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] tbl(input int i);
        case (i)
            0:       return 16'h1280;
            1:       return 16'h1101;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Reference: walk the table, consume one response code per attempt.
    task automatic model(output logic exp_err, output int exp_idx);
        int k, idx, retry, c;
        logic [15:0] e;
        bit fin, more;
        k = 0; idx = 0; exp_err = 1'b0; exp_idx = 0; fin = 1'b0;
        while (!fin) begin
            e = tbl(idx);
            if (e == 16'hFFFF) begin
                exp_idx = idx;
                fin = 1'b1;
            end else begin
                retry = 0;
                more = 1'b1;
                while (more) begin
                    c = (k < codes.size()) ? codes[k] : C_ACK;
                    k++;
                    exp_q.push_back(e);
                    if (c == C_ACK) begin
                        more = 1'b0;
                    end else if (retry < MAXR) begin
                        retry++;
                    end else begin
                        exp_err = 1'b1;
                        exp_idx = idx;
                        fin = 1'b1;
                        more = 1'b0;
                    end
                end
                if (!fin) idx++;
            end
        end
    endtask

    // Engine model: answer each request per the response-code queue.
    initial begin
        int code, d;
        forever begin
            do @(negedge clk); while (!wr_req);
            code = (resp_q.size() > 0) ? resp_q.pop_front() : C_ACK;
            d = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 8));
            repeat (d) @(negedge clk);
            if (code != C_NONE) begin
                wr_ack  = (code == C_ACK) || (code == C_BOTH);
                wr_nack = (code == C_NACK) || (code == C_BOTH);
                ack_q.push_back(cyc);
                @(negedge clk);
                wr_ack  = 1'b0;
                wr_nack = 1'b0;
            end
            while (wr_req) @(negedge clk);
        end
    end

    // Scoreboard monitor: every new request is compared with the next expected write.
    initial begin
        logic prev;
        logic [15:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_req && !prev) begin
                rise_q.push_back(cyc);
                check("busy_during_write", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got %h, expected no write", {wr_addr, wr_data});
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr_data", 32'({wr_addr, wr_data}), 32'(e));
                end
            end
            prev = wr_req;
        end
    end

    // Engine model for the two-entry instance: always acknowledges.
    initial begin
        forever begin
            do @(negedge clk); while (!wr_req2);
            cnt2++;
            last2 = {wr_addr2, wr_data2};
            repeat (3) @(negedge clk);
            wr_ack2 = 1'b1;
            @(negedge clk);
            wr_ack2 = 1'b0;
            while (wr_req2) @(negedge clk);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check({name, "_end_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!wr_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, "_req_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic prep(input int dly, output logic exp_err, output int exp_idx);
        exp_q.delete();
        rise_q.delete();
        ack_q.delete();
        resp_q = codes;
        fixed_dly = dly;
        model(exp_err, exp_idx);
    endtask

    task automatic finish_check(input string name, input logic exp_err, input int exp_idx);
        wait_end(name);
        check({name, "_error"}, 32'(error), 32'(exp_err));
        check({name, "_done"}, 32'(done), 32'(!exp_err));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_wr_req"}, 32'(wr_req), 32'd0);
        check({name, "_reg_idx"}, 32'(reg_idx), 32'(exp_idx));
        check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run(input string name, input int dly);
        logic ee;
        int ei;
        prep(dly, ee, ei);
        pulse_start();
        finish_check(name, ee, ei);
    endtask

    initial begin
        logic ee;
        int ei, r;

        repeat (3) @(negedge clk);
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_reg_idx", 32'(reg_idx), 32'd0);
        check("rst_addr_data", 32'({wr_addr, wr_data}), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All writes acknowledged 10 cycles after the request.
        codes = {};
        run("all_ack", 10);
        check("start_latency", (rise_q.size() > 0) ? 32'(rise_q[0] - start_cyc) : 32'hFFFFFFFF, 32'd3);
        check("soft_reset_gap", (rise_q.size() > 1 && ack_q.size() > 0) ?
              32'(rise_q[1] - ack_q[0] - 1) : 32'hFFFFFFFF, 32'(RST_D + 2));

        // Entry 1 NACKed twice then acknowledged.
        codes = {C_ACK, C_NACK, C_NACK, C_ACK};
        run("retry_ok", 4);
        check("retry_gap", (rise_q.size() > 2 && ack_q.size() > 1) ?
              32'(rise_q[2] - ack_q[1] - 1) : 32'hFFFFFFFF, 32'(GAP));

        // Entry 1 NACKed four times, then a restart from ERROR.
        codes = {C_ACK, C_NACK, C_NACK, C_NACK, C_NACK};
        run("retry_fail", 4);
        codes = {};
        run("restart_after_error", 3);

        // No response at all: every attempt times out.
        codes = {C_NONE, C_NONE, C_NONE, C_NONE};
        run("timeout", 2);
        check("timeout_period", (rise_q.size() > 1) ? 32'(rise_q[1] - rise_q[0]) : 32'hFFFFFFFF,
              32'(TMO + 1 + GAP));

        // ACK and NACK together count as NACK.
        codes = {C_ACK, C_BOTH, C_ACK};
        run("ack_and_nack", 5);

        // start during WAIT_ACK must be ignored.
        codes = {};
        prep(10, ee, ei);
        pulse_start();
        wait_req("poke");
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_check("start_while_busy", ee, ei);

        // Reset in the middle of WAIT_ACK.
        codes = {C_NONE, C_NONE};
        prep(2, ee, ei);
        pulse_start();
        wait_req("midrst");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_wr_req", 32'(wr_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_reg_idx", 32'(reg_idx), 32'd0);
        check("midrst_addr_data", 32'({wr_addr, wr_data}), 32'd0);
        check("midrst_done_error", 32'({done, error}), 32'd0);
        exp_q.delete();
        resp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        codes = {};
        run("after_reset", 6);

        // Randomised response patterns.
        for (int it = 0; it < 20; it++) begin
            codes = {};
            for (int j = 0; j < 12; j++) begin
                r = int'($urandom_range(0, 9));
                codes.push_back((r < 6) ? C_ACK : (r < 8) ? C_NACK : (r < 9) ? C_BOTH : C_NONE);
            end
            run("random", 0);
        end

        // Last table index reached without an end marker.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        r = 0;
        while (!(done2 || error2) && r < 2000) begin
            @(negedge clk);
            r++;
        end
        check("depth_end_writes", 32'(cnt2), 32'd2);
        check("depth_end_last", 32'(last2), 32'h1101);
        check("depth_end_flags", 32'({done2, error2, busy2}), 32'b100);
        check("depth_end_reg_idx", 32'(reg_idx2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
